hazard_fwd_ctrl: RTL
====================

Name: hazard_fwd_ctrl

Overview:
- Parametrised next-generation forwarding/hazard unit for the 5-stage pipeline CPU (F/D/E/M/W).
- Generates per-read-port forward selects for the D stage (branch compare) and the E stage (ALU operands).
- Detects load-use and branch-on-load hazards and drives stall/flush.
- Freezes the pipeline on variable-latency memory and tracks memory waits with a registered FSM and watchdog.

Parameters:
ADDR_W, 5, register address width
NUM_RD, 2, read ports per instruction (port 0 = Rs, port 1 = Rt, extras appended)
TMO_W, 8, width of memory-wait watchdog counter
MEM_TIMEOUT, 200, max consecutive MEM_WAIT cycles before error (must be < 2**TMO_W)
CNT_W, 16, width of stall performance counters

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
RdAddr_D  in  NUM_RD*ADDR_W  source register addresses in D, port i at [i*ADDR_W +: ADDR_W]
RdAddr_E  in  NUM_RD*ADDR_W  source register addresses in E
RegDstAddr_E / RegDstAddr_M / RegDstAddr_W  in  ADDR_W each  destination address per stage
RegWriteEN_E / RegWriteEN_M / RegWriteEN_W  in  1 each  write enable per stage
MemRead_E, MemRead_M  in  1  instruction in stage is a load
MemReady_M  in  1  data memory response valid this cycle
Branch_D  in  1  D-stage instruction is beq/bne (uses D forward selects)
FwdSel_D  out  NUM_RD*2  per port: 0 regfile, 1 E ALU result, 2 M result, 3 W result
FwdSel_E  out  NUM_RD*2  per port: 0 pipeline reg, 1 M result, 2 W result, 3 unused
Stall_F, Stall_D  out  1  hold PC / IF-ID register
Flush_E  out  1  insert bubble into ID-EX
Freeze_EM  out  1  hold ID-EX, EX-MEM and block MEM-WB advance
MemTimeout_ERR  out  1  sticky, set on watchdog expiry
LoadUseCnt, BranchStallCnt, MemWaitCnt  out  CNT_W each  saturating stall counters

Behaviour:
- Match definition: a stage X matches port i when RegWriteEN_X = 1, RegDstAddr_X != 0 and RegDstAddr_X == port i address.
- FwdSel_D priority, nearest stage wins:
  - E match (non-load only) -> 1; else M match -> 2; else W match -> 3; else 0.
  - An E-stage load match gives 0 and raises the load-use hazard instead.
- FwdSel_E priority: M match -> 1; else W match -> 2; else 0. M always overrides W.
- All selects are combinational from the inputs. They are forced to 0 while in MEM_WAIT or while reset is asserted.
- Hazards (combinational):
  - LU: MemRead_E and an E match on any D port.
  - BRL: Branch_D, MemRead_M, and an M match on any D port.
- FSM states RUN, MEM_WAIT, ERR. Registered; async reset to RUN.
- RUN:
  - If MemRead_M and !MemReady_M: Freeze_EM = Stall_F = Stall_D = 1, Flush_E = 0; next state MEM_WAIT.
  - Else if LU or BRL: Stall_F = Stall_D = Flush_E = 1 for this cycle; stay in RUN.
  - Each hazard lasts exactly one cycle because the producer advances.
- MEM_WAIT:
  - Freeze_EM = Stall_F = Stall_D = 1, Flush_E = 0, watchdog counter increments each cycle.
  - On MemReady_M = 1: counter clears, next state RUN. That cycle is still frozen; M data is captured at that edge.
  - When the counter reaches MEM_TIMEOUT: MemTimeout_ERR is set; next state ERR.
- ERR: all stalls held at 1; exit only by reset.
- Simultaneous events: a memory wait takes precedence over LU/BRL. The hazard is re-evaluated after the freeze ends.
- Reset (including mid-MEM_WAIT) clears state, watchdog, error, counters and all outputs to 0.
- Counters saturate at all ones:
  - LoadUseCnt counts LU stall cycles.
  - BranchStallCnt counts BRL stall cycles (BRL-only; cycles with both LU and BRL count as LU).
  - MemWaitCnt counts frozen cycles.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: the three counters are implemented as described.
- Undefined: counter registers are omitted and LoadUseCnt/BranchStallCnt/MemWaitCnt are tied to 0. Forwarding, stall and FSM behaviour are unchanged.

Test Plan:
- R-type chain: RegDstAddr_M = 8 with write enable, RegDstAddr_W = 8 with write enable, RdAddr_E port0 = 8 -> FwdSel_E port0 = 1 (M wins), no stall.
- Load-use: MemRead_E = 1, RegDstAddr_E = 9, RegWriteEN_E = 1, RdAddr_D port1 = 9 -> Stall_F = Stall_D = Flush_E = 1 for one cycle, LoadUseCnt = 1; next cycle (load in M) FwdSel_D port1 = 2, no stall.
- Branch-on-load: Branch_D = 1, MemRead_M = 1, MemReady_M = 1, RegDstAddr_M = 4, RdAddr_D port0 = 4 -> one stall cycle, BranchStallCnt = 1.
- Zero register: RegDstAddr_E = RegDstAddr_M = RegDstAddr_W = 0, all enables set, all ports read 0 -> all selects 0, no stall.
- Memory wait: MemRead_M = 1, MemReady_M held low 5 cycles then high -> Freeze_EM high 6 cycles, MemWaitCnt = 6, returns to RUN. Separately, hold MemReady_M low for MEM_TIMEOUT + 1 cycles -> MemTimeout_ERR = 1, stalls held until RST_N is pulsed.
- Reset while in MEM_WAIT: assert RST_N = 0 asynchronously -> outputs 0 immediately, state RUN after release.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding/hazard unit for the 5-stage pipeline: D/E forward selects, load-use and
// branch-on-load stalls, memory-wait freeze FSM with watchdog. Optional macro HAZ_PERF_CNT_EN adds stall counters.
module hazard_fwd_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int NUM_RD      = 2,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200,
  parameter int CNT_W       = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr_D,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr_E,
  input  logic [ADDR_W-1:0]        RegDstAddr_E,
  input  logic [ADDR_W-1:0]        RegDstAddr_M,
  input  logic [ADDR_W-1:0]        RegDstAddr_W,
  input  logic                     RegWriteEN_E,
  input  logic                     RegWriteEN_M,
  input  logic                     RegWriteEN_W,
  input  logic                     MemRead_E,
  input  logic                     MemRead_M,
  input  logic                     MemReady_M,
  input  logic                     Branch_D,
  output logic [NUM_RD*2-1:0]      FwdSel_D,
  output logic [NUM_RD*2-1:0]      FwdSel_E,
  output logic                     Stall_F,
  output logic                     Stall_D,
  output logic                     Flush_E,
  output logic                     Freeze_EM,
  output logic                     MemTimeout_ERR,
  output logic [CNT_W-1:0]         LoadUseCnt,
  output logic [CNT_W-1:0]         BranchStallCnt,
  output logic [CNT_W-1:0]         MemWaitCnt
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERR      = 2'd2;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  logic [1:0]        stateReg, stateNext;
  logic [TMO_W-1:0]  wdReg, wdNext, wdInc;
  logic              errReg, errNext;
  logic [NUM_RD-1:0] matchDE, matchDM, matchDW, matchEM, matchEW;
  logic              selGate, loadUse, branchLoad, memMiss;
  logic              stallRaw, flushRaw, freezeRaw;

  assign selGate = !RST_N || (stateReg == MEM_WAIT);

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : gPort
    logic [ADDR_W-1:0] addrD, addrE;
    logic [1:0]        selD, selE;

    assign addrD = RdAddr_D[gi*ADDR_W +: ADDR_W];
    assign addrE = RdAddr_E[gi*ADDR_W +: ADDR_W];

    assign matchDE[gi] = RegWriteEN_E && (RegDstAddr_E != '0) && (RegDstAddr_E == addrD);
    assign matchDM[gi] = RegWriteEN_M && (RegDstAddr_M != '0) && (RegDstAddr_M == addrD);
    assign matchDW[gi] = RegWriteEN_W && (RegDstAddr_W != '0) && (RegDstAddr_W == addrD);
    assign matchEM[gi] = RegWriteEN_M && (RegDstAddr_M != '0) && (RegDstAddr_M == addrE);
    assign matchEW[gi] = RegWriteEN_W && (RegDstAddr_W != '0) && (RegDstAddr_W == addrE);

    // A load in E cannot forward yet; the port reads 0 and the load-use stall covers it.
    always_comb begin
      selD = 2'd0;
      if (matchDE[gi])      selD = MemRead_E ? 2'd0 : 2'd1;
      else if (matchDM[gi]) selD = 2'd2;
      else if (matchDW[gi]) selD = 2'd3;
    end

    always_comb begin
      selE = 2'd0;
      if (matchEM[gi])      selE = 2'd1;
      else if (matchEW[gi]) selE = 2'd2;
    end

    assign FwdSel_D[gi*2 +: 2] = selGate ? 2'd0 : selD;
    assign FwdSel_E[gi*2 +: 2] = selGate ? 2'd0 : selE;
  end

  assign loadUse    = MemRead_E && (|matchDE);
  assign branchLoad = Branch_D && MemRead_M && (|matchDM);
  assign memMiss    = MemRead_M && !MemReady_M;
  assign wdInc      = wdReg + 1'b1;

  always_comb begin
    stateNext = stateReg;
    wdNext    = wdReg;
    errNext   = errReg;
    stallRaw  = 1'b0;
    flushRaw  = 1'b0;
    freezeRaw = 1'b0;
    case (stateReg)
      RUN: begin
        if (memMiss) begin
          freezeRaw = 1'b1;
          stallRaw  = 1'b1;
          wdNext    = '0;
          stateNext = MEM_WAIT;
        end else if (loadUse || branchLoad) begin
          stallRaw = 1'b1;
          flushRaw = 1'b1;
        end
      end
      MEM_WAIT: begin
        freezeRaw = 1'b1;
        stallRaw  = 1'b1;
        if (MemReady_M) begin
          wdNext    = '0;
          stateNext = RUN;
        end else begin
          wdNext = wdInc;
          if (wdInc == TMO_LIMIT) begin
            errNext   = 1'b1;
            stateNext = ERR;
          end
        end
      end
      ERR: begin
        freezeRaw = 1'b1;
        stallRaw  = 1'b1;
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stateReg <= RUN;
      wdReg    <= '0;
      errReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      wdReg    <= wdNext;
      errReg   <= errNext;
    end
  end

  // Gating with RST_N makes every output drop the moment reset asserts.
  assign Stall_F        = RST_N && stallRaw;
  assign Stall_D        = RST_N && stallRaw;
  assign Flush_E        = RST_N && flushRaw;
  assign Freeze_EM      = RST_N && freezeRaw;
  assign MemTimeout_ERR = errReg;

`ifdef HAZ_PERF_CNT_EN
  logic             luStall, brStall;
  logic [CNT_W-1:0] luCntReg, brCntReg, mwCntReg;

  assign luStall = (stateReg == RUN) && !memMiss && loadUse;
  assign brStall = (stateReg == RUN) && !memMiss && branchLoad && !loadUse;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      luCntReg <= '0;
      brCntReg <= '0;
      mwCntReg <= '0;
    end else begin
      if (luStall && (luCntReg != '1))   luCntReg <= luCntReg + 1'b1;
      if (brStall && (brCntReg != '1))   brCntReg <= brCntReg + 1'b1;
      if (freezeRaw && (mwCntReg != '1)) mwCntReg <= mwCntReg + 1'b1;
    end
  end

  assign LoadUseCnt     = luCntReg;
  assign BranchStallCnt = brCntReg;
  assign MemWaitCnt     = mwCntReg;
`else
  assign LoadUseCnt     = '0;
  assign BranchStallCnt = '0;
  assign MemWaitCnt     = '0;
`endif

endmodule
